seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
Downstream display stage for the counter/clock-divider chain. Takes a 16-bit value (four hex nibbles) from an upstream counter and time-multiplexes it onto the board's 4-digit common-anode 7-segment display. Uses an internal prescaler enable with no derived clocks. Adds per-digit blank-before-drive to prevent ghosting, frame-coherent input capture and leading-zero suppression.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz slot at 100 MHz); legal range 2..2^20
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-1

Ports:
clk  input  1  system clock, sole clock domain
rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
value  input  16  four hex digits; digit0 = value[3:0] (rightmost), digit3 = value[15:12]
dp  input  4  decimal point request per digit, 1 = lit
blank  input  4  per-digit force-blank, 1 = digit dark
lz_en  input  1  leading-zero suppression enable
an  output  4  anode enables, active-low, an[i] drives digit i
seg  output  7  cathodes, active-low, seg[0]=a .. seg[6]=g
dp_n  output  1  decimal-point cathode, active-low
frame_tick  output  1  one-cycle pulse marking a new input capture

Behaviour:
- Reset (rst=0 at posedge): cnt=0, idx=0, shadow regs (value/dp/blank/lz_en)=0, an=4'b1111, seg=7'b1111111, dp_n=1, frame_tick=0. Reset mid-frame aborts the scan and forces these values on the same edge.
- Slot counter: cnt counts 0..SCAN_DIV-1 and wraps to 0. On wrap, idx increments mod 4 (3 -> 0).
- Capture: on each edge where idx==0 && cnt==0, value/dp/blank/lz_en load into shadow regs. All decoding uses only the shadow regs, so input changes mid-frame have no effect until the next frame.
- frame_tick: registered. High for exactly the one cycle after a capture edge. One pulse per 4*SCAN_DIV cycles.
- Slot phases per digit idx:
  - BLANK phase, cnt < BLANK_CYCLES: an=1111, seg=1111111, dp_n=1.
  - DRIVE phase, cnt >= BLANK_CYCLES: an = one-hot-low at idx unless the digit is dark.
- Digit dark if shadow blank[idx]=1, or it is suppressed. A dark digit gives an=1111, seg=all 1, dp_n=1 for the whole slot.
- Suppression: with lz_en=1, digit k (k=3,2,1) is suppressed iff nibbles k..3 are all zero. Digit0 is never suppressed; value 0 shows a single "0".
- dp_n = ~shadow dp[idx] during DRIVE of a non-dark digit.
- Output latency: an/seg/dp_n are registered, decoded from the (cnt, idx, shadow) present in the previous cycle. After reset release, digit0's anode first goes low at cycle BLANK_CYCLES+1, counting the first non-reset edge as cycle 1.
- Hex decode, active-low {g,f,e,d,c,b,a}:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Invariant: at most one an bit is low in any cycle. an never switches directly from one digit to another without at least BLANK_CYCLES cycles of 1111 between them.

Test Plan:
1. SCAN_DIV=8, BLANK_CYCLES=2, value=16'h1234, dp=0, blank=0, lz_en=0 -> each 8-cycle slot shows 2 cycles an=1111, then 6 cycles of the digit:
   - digit0: an=1110, seg=0011001 ("4")
   - digit1: an=1101, seg=0110000 ("3")
   - digit2: an=1011, seg=0100100 ("2")
   - digit3: an=0111, seg=1111001 ("1")
   - frame_tick pulses every 32 cycles.
2. Same params, change value to 16'hABCD at cycle 5 of frame -> remainder of frame still shows 1234; next frame (after frame_tick) shows D,C,b,A patterns.
3. value=16'h0070, lz_en=1 -> digits 3,2 dark (an=1111 entire slot); digit1 shows "7" (1111000); digit0 shows "0" (1000000). Then value=0 -> only digit0 lit with "0".
4. blank=4'b0010, dp=4'b0101, value=16'h8888 -> digit1 slot fully dark; digits 0 and 2 show seg=0000000 with dp_n=0; digit3 shows seg=0000000 with dp_n=1.
5. Assert rst=0 for one cycle during digit2 DRIVE -> next edge gives an=1111, seg=1111111, dp_n=1, frame_tick=0; scan restarts at digit0 with fresh capture, frame_tick after first capture.
6. Defaults, 10 full frames of random value/dp/blank/lz_en -> assertion checker: one-hot-low an, ≥BLANK_CYCLES dark gap between digits, decode matches the golden table.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// It blanks each digit before driving it, captures its inputs once per frame and suppresses leading zeros.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX     = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_START = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_value;
    logic [3:0]    sh_dp;
    logic [3:0]    sh_blank;
    logic          sh_lz;

    logic          frame_start;
    logic [3:0]    nibble;
    logic [3:0]    upper_zero;
    logic          dark;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_n_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign frame_start = (idx == 2'd0) && (cnt == '0);
    assign nibble      = sh_value[{idx, 2'b00} +: 4];

    // upper_zero[k]: nibbles k..3 are all zero; digit0 is never a candidate for suppression
    always_comb begin
        upper_zero[3] = (sh_value[15:12] == 4'h0);
        upper_zero[2] = upper_zero[3] && (sh_value[11:8] == 4'h0);
        upper_zero[1] = upper_zero[2] && (sh_value[7:4] == 4'h0);
        upper_zero[0] = 1'b0;
    end

    assign dark = sh_blank[idx] || (sh_lz && upper_zero[idx]);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        an_d   = 4'b1111;
        seg_d  = 7'b1111111;
        dp_n_d = 1'b1;
        if (cnt >= BLANK_START && !dark) begin
            an_d   = ~(4'b0001 << idx);
            seg_d  = hex_to_seg(nibble);
            dp_n_d = ~sh_dp[idx];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            sh_value   <= 16'h0000;
            sh_dp      <= 4'h0;
            sh_blank   <= 4'h0;
            sh_lz      <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_start) begin
                sh_value <= value;
                sh_dp    <= dp;
                sh_blank <= blank;
                sh_lz    <= lz_en;
            end
            frame_tick <= frame_start;
            an         <= an_d;
            seg        <= seg_d;
            dp_n       <= dp_n_d;
        end
    end

endmodule
